d_ff_advanced_reg: RTL and testbench

- Parameterised D-type register with clock enable, synchronous clear and a second "async" clear input.
- Used as the generic holding register for control and status bits in sequential datapaths.
- Default build is fully synchronous. An optional build makes the `reset_async` clear truly asynchronous, with a synchronised release.

---
 rtl/d_ff_advanced_pkg.sv | 23 ++
 rtl/d_ff_advanced_rst_sync.sv | 25 ++
 rtl/d_ff_advanced_reg.sv | 71 +++++++
 tb/tb_d_ff_advanced_reg.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/d_ff_advanced_pkg.sv
// Shared constants for the d_ff_advanced register family: parameter defaults and next-state select codes.
// Optional build macro: D_FF_ADVANCED_ASYNC_RST_EN (see d_ff_advanced_reg).
package d_ff_advanced_pkg;

    localparam int unsigned DEFAULT_WIDTH       = 1;
    localparam logic [63:0] DEFAULT_RESET_VAL   = 64'd0;
    localparam int unsigned DEFAULT_SYNC_STAGES = 2;

    localparam logic [1:0] CLR  = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
    localparam logic [1:0] HOLD = 2'd2;

    // Clear beats load, and load beats hold.
    function automatic logic [1:0] next_sel(input logic clr, input logic load);
        if (clr) begin
            return CLR;
        end else if (load) begin
            return LOAD;
        end
        return HOLD;
    endfunction

endpackage

// File: rtl/d_ff_advanced_rst_sync.sv
// Async-assert / sync-release reset synchroniser; clr rises with reset_async and falls SYNC_STAGES clk edges after it drops.
// Used only when D_FF_ADVANCED_ASYNC_RST_EN is defined.
module d_ff_advanced_rst_sync
    import d_ff_advanced_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
    input  logic clk,
    input  logic reset_async,
    output logic clr
);

    logic [SYNC_STAGES-1:0] stages;

    always_ff @(posedge clk or posedge reset_async) begin
        if (reset_async) begin
            stages <= '1;
        end else begin
            stages <= {stages[SYNC_STAGES-2:0], 1'b0};
        end
    end

    assign clr = stages[SYNC_STAGES-1];

endmodule

// File: rtl/d_ff_advanced_reg.sv
// Parameterised D register with enable, synchronous clear and a second clear that becomes truly asynchronous
// (with synchronised release) when D_FF_ADVANCED_ASYNC_RST_EN is defined; the default build is fully synchronous.
module d_ff_advanced_reg
    import d_ff_advanced_pkg::*;
#(
    parameter int unsigned WIDTH       = DEFAULT_WIDTH,
    parameter logic [63:0] RESET_VAL   = DEFAULT_RESET_VAL,
    parameter int unsigned SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
    input  logic             clk,
    input  logic             reset_sync,
    input  logic             reset_async,
    input  logic             enable,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q
);

    localparam logic [WIDTH-1:0] RST_Q = RESET_VAL[WIDTH-1:0];

    if (WIDTH < 1 || WIDTH > 64) begin : g_bad_width
        $error("d_ff_advanced_reg: WIDTH must be 1..64");
    end
    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_stages
        $error("d_ff_advanced_reg: SYNC_STAGES must be 2..4");
    end

    logic             clr;
    logic [1:0]       sel;
    logic [WIDTH-1:0] q_next;

`ifdef D_FF_ADVANCED_ASYNC_RST_EN
    logic clr_async;

    d_ff_advanced_rst_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_rst_sync (
        .clk        (clk),
        .reset_async(reset_async),
        .clr        (clr_async)
    );

    // reset_async reaches Q only through the synchroniser's async clear.
    assign clr = reset_sync;

    always_ff @(posedge clk or posedge clr_async) begin
        if (clr_async) begin
            Q <= RST_Q;
        end else begin
            Q <= q_next;
        end
    end
`else
    assign clr = reset_async | reset_sync;

    always_ff @(posedge clk) begin
        Q <= q_next;
    end
`endif

    assign sel = next_sel(clr, enable);

    always_comb begin
        q_next = Q;
        case (sel)
            CLR:     q_next = RST_Q;
            LOAD:    q_next = D;
            default: q_next = Q;
        endcase
    end

endmodule

// File: tb/tb_d_ff_advanced_reg.sv
// Directed bench for d_ff_advanced_reg: a 1-bit/RESET_VAL=0 instance and an 8-bit/RESET_VAL=8'hA5 instance share controls.
module tb_d_ff_advanced_reg;

    logic       clk = 1'b0;
    logic       reset_sync;
    logic       reset_async;
    logic       enable;
    logic       d1;
    logic [7:0] d8;
    logic       q1;
    logic [7:0] q8;

    int checks = 0;
    int errors = 0;

    logic [8:0] exp_q[$];
    logic       m1;
    logic [7:0] m8;

    always #5 clk = ~clk;

    d_ff_advanced_reg #(
        .WIDTH    (1),
        .RESET_VAL(64'd0)
    ) dut1 (
        .clk        (clk),
        .reset_sync (reset_sync),
        .reset_async(reset_async),
        .enable     (enable),
        .D          (d1),
        .Q          (q1)
    );

    d_ff_advanced_reg #(
        .WIDTH    (8),
        .RESET_VAL(64'hA5)
    ) dut8 (
        .clk        (clk),
        .reset_sync (reset_sync),
        .reset_async(reset_async),
        .enable     (enable),
        .D          (d8),
        .Q          (q8)
    );

    task automatic compare(input string tag);
        logic [8:0] exp;
        logic [8:0] got;
        exp = exp_q.pop_front();
        got = {q8, q1};
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, got, exp);
        end
    endtask

    // Drive one cycle of inputs at the falling edge, predict Q, then check just after the rising edge.
    task automatic step(input logic rs, input logic ra, input logic en,
                        input logic d1_v, input logic [7:0] d8_v, input string tag);
        @(negedge clk);
        reset_sync  = rs;
        reset_async = ra;
        enable      = en;
        d1          = d1_v;
        d8          = d8_v;
        if (rs || ra) begin
            m1 = 1'b0;
            m8 = 8'hA5;
        end else if (en) begin
            m1 = d1_v;
            m8 = d8_v;
        end
        exp_q.push_back({m8, m1});
        @(posedge clk);
        #1;
        compare(tag);
    endtask

    initial begin
        reset_sync  = 1'b1;
        reset_async = 1'b1;
        enable      = 1'b0;
        d1          = 1'b0;
        d8          = 8'h00;
        m1          = 1'bx;
        m8          = 8'hxx;

        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b1, 1'b0, 1'(i % 2), 8'($urandom_range(0, 255)), "powerup");
        end
        step(1'b0, 1'b0, 1'b0, 1'b1, 8'h3C, "release0");
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'hC3, "release1");

        for (int i = 0; i < 8; i++) begin
            if (i == 3) begin
                step(1'b0, 1'b0, 1'b0, 1'bx, 8'hxx, "hold_x");
            end else begin
                step(1'b0, 1'b0, 1'b0, (i % 2 == 0), 8'($urandom_range(0, 255)), "hold");
            end
        end

        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b0, 1'b1, (i % 2 == 0), 8'($urandom_range(0, 255)), "load");
        end

        step(1'b0, 1'b0, 1'b1, 1'b1, 8'h3C, "rs_pre");
        step(1'b1, 1'b0, 1'b1, 1'b1, 8'h3C, "rs_pulse");
        step(1'b0, 1'b0, 1'b1, 1'b1, 8'h3C, "rs_after");
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, "rs_hold");

`ifndef D_FF_ADVANCED_ASYNC_RST_EN
        step(1'b0, 1'b1, 1'b1, 1'b1, 8'h3C, "ra_pulse");
        step(1'b0, 1'b0, 1'b1, 1'b1, 8'h3C, "ra_after");
        step(1'b1, 1'b1, 1'b1, 1'b1, 8'h3C, "both_rst");
        step(1'b0, 1'b0, 1'b1, 1'b1, 8'h5A, "both_after");
        for (int i = 0; i < 24; i++) begin
            step(($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), "random");
        end
`else
        for (int i = 0; i < 24; i++) begin
            step(($urandom_range(0, 7) == 0), 1'b0, 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), "random");
        end
`endif

        step(1'b0, 1'b0, 1'b1, 1'bx, 8'hxx, "x_load");
        step(1'b0, 1'b0, 1'b1, 1'b0, 8'h81, "x_recover");

`ifdef D_FF_ADVANCED_ASYNC_RST_EN
        step(1'b0, 1'b0, 1'b1, 1'b1, 8'h3C, "async_pre");
        #2;
        reset_async = 1'b1;
        #1;
        exp_q.push_back({8'hA5, 1'b0});
        compare("async_assert");
        @(negedge clk);
        reset_async = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            exp_q.push_back({8'hA5, 1'b0});
            compare("async_release_hold");
        end
        @(posedge clk);
        #1;
        exp_q.push_back({8'h3C, 1'b1});
        compare("async_first_load");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
